// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared types and helpers for the NPC load/store unit.
//   size_e        : access size encoding (byte/half/word/double)
//   state_e       : LSU handshake FSM states
//   is_misaligned : 1 when the low address bits are not a multiple of the size
//   size_bytes    : number of bytes touched by an access of the given size
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Only the three low address bits matter for any legal access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: combinational lane logic for the LSU.
//   addr_lo_i   : byte offset of the access within the aligned XLEN word
//   size_i      : access size (size_e encoding)
//   unsigned_i  : zero-extend instead of sign-extend the load result
//   wdata_i     : right-aligned store data
//   rdata_i     : full aligned word returned by memory
//   wmask_o     : byte strobes for a store of this size at this lane
//   wdata_o     : low 2^size bytes of wdata_i replicated across all lanes
//   rdata_o     : selected lane, sign- or zero-extended to XLEN
module npc_lsu_align
  import npc_lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  logic [LW-1:0]   addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [3:0]      nbytes;
  logic [NB-1:0]   ones;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] low_mask;
  logic            sign;

  // Write strobes: a contiguous run of nbytes ones shifted to the lane.
  // Aligned accesses never shift ones past the top lane.
  always_comb begin
    nbytes  = size_bytes(size_i);
    ones    = (32'(nbytes) >= NB) ? '1 : ((NB'(1) << nbytes) - NB'(1));
    wmask_o = ones << addr_lo_i;
  end

  always_comb begin
    wdata_o = wdata_i;
    case (size_e'(size_i))
      SZ_B:    wdata_o = {NB{wdata_i[7:0]}};
      SZ_H:    wdata_o = {(NB/2){wdata_i[15:0]}};
      SZ_W:    wdata_o = {(NB/4){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, keep the access
  // width and fill the rest with the sign bit (or zeros when unsigned).
  always_comb begin
    shifted  = rdata_i >> {addr_lo_i, 3'b000};
    low_mask = '1;
    sign     = 1'b0;
    case (size_e'(size_i))
      SZ_B: begin
        low_mask = XLEN'(8'hFF);
        sign     = shifted[7];
      end
      SZ_H: begin
        low_mask = XLEN'(16'hFFFF);
        sign     = shifted[15];
      end
      SZ_W: begin
        low_mask = XLEN'(32'hFFFF_FFFF);
        sign     = shifted[31];
      end
      default: begin
        low_mask = '1;
        sign     = 1'b0;
      end
    endcase
    rdata_o = (shifted & low_mask) | ({XLEN{sign & ~unsigned_i}} & ~low_mask);
  end

endmodule

// File: rtl/npc_lsu_hs.sv
// npc_lsu_hs: load/store unit with a valid/ready handshake toward memory.
//   clk, rst            : clock, synchronous active-low reset
//   req_*               : EXU request (store flag, size, unsigned, address, data)
//   resp_*              : EXU response (extended load data, error flag)
//   mem_req_*, mem_wen, mem_addr, mem_wdata, mem_wmask : aligned memory request
//   mem_resp_*, mem_rdata                              : memory response / write-ack
//
// Handshake rule on every channel: a transfer happens at a rising clk edge
// where valid and ready are both 1; once valid is raised, valid and its
// payload stay unchanged until that transfer (the only exception is an
// abandoned memory request on timeout or reset).
//
// Flow: IDLE accepts one request; a misaligned or illegal-size request goes
// straight to RESP with an error. Otherwise REQ presents the aligned memory
// request, WAIT takes the response or write-ack, and RESP holds the result
// until the EXU takes it. A timeout counter covers REQ+WAIT; if memory already
// owes us a response when the timeout fires, the drain flag swallows it later.
module npc_lsu_hs
  import npc_lsu_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int TIMEOUT = 256,
  localparam int NB      = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int             LW      = $clog2(NB);
  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            drain_q;
  logic            wen_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            in_idle, in_req, in_wait, in_resp;
  logic            accept;
  logic            bad_req;
  logic            timeout_hit;
  logic [NB-1:0]   al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  npc_lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i  (addr_q[LW-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  assign in_idle = (state_q == IDLE);
  assign in_req  = (state_q == REQ);
  assign in_wait = (state_q == WAIT);
  assign in_resp = (state_q == RESP);

  // Every handshake output is gated by rst so the interface is quiet for
  // the whole time reset is held, not just after the first reset edge.
  assign req_ready      = rst && in_idle && !drain_q;
  assign mem_req_valid  = rst && in_req;
  assign mem_resp_ready = rst && (in_wait || (drain_q && (in_idle || in_resp)));
  assign resp_valid     = rst && in_resp;

  assign mem_wen    = mem_req_valid && wen_q;
  assign mem_addr   = mem_req_valid ? {addr_q[XLEN-1:LW], {LW{1'b0}}} : '0;
  assign mem_wdata  = mem_wen ? al_wdata : '0;
  assign mem_wmask  = mem_wen ? al_wmask : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;

  assign accept      = req_valid && req_ready;
  assign bad_req     = is_misaligned(req_addr[2:0], req_size) ||
                       ((XLEN == 32) && (req_size == 2'd3));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // The late response of a timed-out access is swallowed here.
      if (drain_q && mem_resp_valid && mem_resp_ready) begin
        drain_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q   <= req_wen;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (bad_req) begin
              state_q <= RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              cnt_q   <= '0;
            end
          end
        end

        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (timeout_hit) begin
            state_q <= RESP;
            rdata_q <= '0;
            err_q   <= 1'b1;
            // Request handed over on the last cycle: memory still owes a reply.
            if (mem_req_ready) drain_q <= 1'b1;
          end else if (mem_req_ready) begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A response arriving on the timeout cycle still completes normally.
          if (mem_resp_valid) begin
            state_q <= RESP;
            rdata_q <= wen_q ? '0 : al_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= RESP;
            rdata_q <= '0;
            err_q   <= 1'b1;
            drain_q <= 1'b1;
          end
        end

        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_lsu_hs.sv
module tb_npc_lsu_hs;

  localparam int XLEN    = 32;
  localparam int NB      = XLEN / 8;
  localparam int TIMEOUT = 8;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_wmask;
  logic            mem_resp_valid;
  logic            mem_resp_ready;
  logic [XLEN-1:0] mem_rdata;

  int n_cmp;
  int n_err;

  npc_lsu_hs #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present one EXU request for a single accepting edge.
  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Zero-wait memory: called in the REQ cycle, returns in the RESP cycle.
  task automatic zero_wait(input string tag, input logic [31:0] rd);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    chk({tag, "_wait_resp_ready"}, 64'(mem_resp_ready), 64'd1);
    chk({tag, "_wait_no_resp"}, 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = $urandom;
  endtask

  // Check the held response and take it.
  task automatic take_resp(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'(exp_rd));
    chk({tag, "_resp_err"},   64'(resp_err),   64'(exp_err));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_resp_done"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_wen        = 1'b0;
    req_size       = 2'd0;
    req_unsigned   = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    resp_ready     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready",      64'(req_ready),      64'd0);
    chk("rst_mem_req_valid",  64'(mem_req_valid),  64'd0);
    chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
    chk("rst_resp_valid",     64'(resp_valid),     64'd0);
    chk("rst_mem_addr",       64'(mem_addr),       64'd0);
    rst = 1'b1;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // lw 0x80000004, zero-wait memory, response in cycle N+3
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0);
    chk("lw_mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("lw_mem_addr",      64'(mem_addr),       64'h8000_0004);
    chk("lw_mem_wmask",     64'(mem_wmask),      64'h0);
    chk("lw_mem_wen",       64'(mem_wen),        64'd0);
    chk("lw_req_ready",     64'(req_ready),      64'd0);
    zero_wait("lw", 32'hDEAD_BEEF);
    take_resp("lw", 32'hDEAD_BEEF, 1'b0);
    chk("lw_back_idle", 64'(req_ready), 64'd1);

    // lh / lhu 0x80000002 of 0x80001234 -> upper half 0x8000
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0);
    chk("lh_mem_addr", 64'(mem_addr), 64'h8000_0000);
    zero_wait("lh", 32'h8000_1234);
    take_resp("lh", 32'hFFFF_8000, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0);
    zero_wait("lhu", 32'h8000_1234);
    take_resp("lhu", 32'h0000_8000, 1'b0);

    // lb 0x80000001 of 0x0000F000 -> byte 0xF0 sign-extended
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0);
    zero_wait("lb", 32'h0000_F000);
    take_resp("lb", 32'hFFFF_FFF0, 1'b0);

    // sb 0x80000003, wdata 0xAB
    issue(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB);
    chk("sb_mem_wen",   64'(mem_wen),   64'd1);
    chk("sb_mem_addr",  64'(mem_addr),  64'h8000_0000);
    chk("sb_mem_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
    chk("sb_mem_wmask", 64'(mem_wmask), 64'b1000);
    zero_wait("sb", 32'($urandom_range(1, 32'h7FFF_FFFF)));
    take_resp("sb", 32'h0, 1'b0);

    // sh 0x80000002, wdata 0x1234BEEF, memory slow to accept for 2 cycles
    issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_BEEF);
    tick();
    tick();
    chk("sh_hold_valid", 64'(mem_req_valid), 64'd1);
    chk("sh_mem_wdata",  64'(mem_wdata),     64'hBEEF_BEEF);
    chk("sh_mem_wmask",  64'(mem_wmask),     64'b1100);
    zero_wait("sh", 32'h5555_5555);
    take_resp("sh", 32'h0, 1'b0);

    // Misaligned lw: no memory request, error one cycle after accept
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0);
    chk("mis_mem_req_valid", 64'(mem_req_valid), 64'd0);
    take_resp("mis", 32'h0, 1'b1);

    // Size 3 with XLEN=32 is illegal
    issue(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0);
    chk("sz3_mem_req_valid", 64'(mem_req_valid), 64'd0);
    take_resp("sz3", 32'h0, 1'b1);

    // Timeout in REQ without handshake: 8 cycles of REQ, no drain afterwards
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    chk("toreq_last_req", 64'(mem_req_valid), 64'd1);
    chk("toreq_no_resp",  64'(resp_valid),    64'd0);
    tick();
    chk("toreq_dropped",   64'(mem_req_valid),  64'd0);
    chk("toreq_no_drain",  64'(mem_resp_ready), 64'd0);
    take_resp("toreq", 32'h0, 1'b1);
    chk("toreq_req_ready", 64'(req_ready), 64'd1);

    // Timeout in WAIT: handshake at once, response withheld
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("towait_no_resp",   64'(resp_valid),     64'd0);
    chk("towait_resp_rdy",  64'(mem_resp_ready), 64'd1);
    tick();
    chk("towait_drain_rdy", 64'(mem_resp_ready), 64'd1);
    take_resp("towait", 32'h0, 1'b1);
    chk("drain_req_ready",  64'(req_ready),      64'd0);
    chk("drain_resp_ready", 64'(mem_resp_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    tick();
    req_valid = 1'b0;
    chk("drain_blocks_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1111_2222;
    tick();
    mem_resp_valid = 1'b0;
    chk("drain_cleared",  64'(req_ready),      64'd1);
    chk("drain_no_resp",  64'(resp_valid),     64'd0);
    chk("drain_rdy_low",  64'(mem_resp_ready), 64'd0);

    // Response held while EXU stalls for 5 cycles
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0);
    zero_wait("stall", 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      mem_rdata = $urandom;
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_rdata", 64'(resp_rdata), 64'hCAFE_0001);
      tick();
    end
    take_resp("stall", 32'hCAFE_0001, 1'b0);

    // Reset in WAIT abandons the access
    issue(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rstw_in_wait", 64'(mem_resp_ready), 64'd1);
    rst = 1'b0;
    #1;
    chk("rstw_quiet", 64'(mem_resp_ready), 64'd0);
    tick();
    chk("rstw_req_ready",  64'(req_ready),     64'd0);
    chk("rstw_resp_valid", 64'(resp_valid),    64'd0);
    chk("rstw_mem_valid",  64'(mem_req_valid), 64'd0);
    chk("rstw_rdata",      64'(resp_rdata),    64'd0);
    rst = 1'b1;
    #1;
    chk("rstw_release_ready", 64'(req_ready),      64'd1);
    chk("rstw_release_mrr",   64'(mem_resp_ready), 64'd0);

    // Normal access after reset
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0);
    chk("post_mem_addr", 64'(mem_addr), 64'h8000_0008);
    zero_wait("post", 32'h0102_0304);
    take_resp("post", 32'h0102_0304, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
